// File: rtl/sweep_counter_if.sv
// sweep_counter_if: control and status bundle between the calibration FSM
// (master) and the sweep counter (slave).
// Optional feature macro: SWEEP_PRESCALE_EN adds the PRESC step-period field.
interface sweep_counter_if #(
   parameter int WIDTH = 13
`ifdef SWEEP_PRESCALE_EN
   , parameter int PRESCALE_W = 8
`endif
);

   logic             EN;
   logic             DIR;
   logic             MODE;
   logic [WIDTH-1:0] LIMIT;
`ifdef SWEEP_PRESCALE_EN
   logic [PRESCALE_W-1:0] PRESC;
`endif
   logic [WIDTH-1:0] POS;
   logic             CNT_EN;
   logic             DONE;
   logic             HEADING;

`ifdef SWEEP_PRESCALE_EN
   modport master (output EN, DIR, MODE, LIMIT, PRESC,
                   input  POS, CNT_EN, DONE, HEADING);
   modport slave  (input  EN, DIR, MODE, LIMIT, PRESC,
                   output POS, CNT_EN, DONE, HEADING);
`else
   modport master (output EN, DIR, MODE, LIMIT,
                   input  POS, CNT_EN, DONE, HEADING);
   modport slave  (input  EN, DIR, MODE, LIMIT,
                   output POS, CNT_EN, DONE, HEADING);
`endif

endinterface

// File: rtl/sweep_counter.sv
// sweep_counter: steps a position between 0 and a latched LIMIT, up or down,
// either once (single-shot) or continuously (bounce), for both servo axes.
// Optional feature macro: SWEEP_PRESCALE_EN adds a PRESC+1 cycle step divider.
module sweep_counter #(
   parameter int WIDTH = 13
`ifdef SWEEP_PRESCALE_EN
   , parameter int PRESCALE_W = 8
`endif
) (
   input logic           CLK,
   input logic           RST_N,
   sweep_counter_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] lim_q;
   logic             mode_q;
   logic [WIDTH-1:0] pos_q;
   logic             heading_q;
   logic             cnt_en_q;
   logic             done_q;

   logic             tick;
   logic [WIDTH-1:0] end_pt;
   logic             at_end;

`ifdef SWEEP_PRESCALE_EN
   logic [PRESCALE_W-1:0] presc_q;
   logic [PRESCALE_W-1:0] div_q;

   assign tick = (div_q == presc_q);
`else
   assign tick = 1'b1;
`endif

   // The end point depends only on the current heading: LIMIT going up, 0 going down.
   assign end_pt = heading_q ? '0 : lim_q;
   assign at_end = (pos_q == end_pt);

   // Sweep FSM: latches the run setup in IDLE, steps or detects the end point in RUN.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= ST_IDLE;
         lim_q     <= '0;
         mode_q    <= 1'b0;
         pos_q     <= '0;
         heading_q <= 1'b0;
         cnt_en_q  <= 1'b0;
         done_q    <= 1'b0;
`ifdef SWEEP_PRESCALE_EN
         presc_q   <= '0;
         div_q     <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         if (!bus.EN) begin
            state_q  <= ST_IDLE;
            pos_q    <= '0;
            cnt_en_q <= 1'b0;
`ifdef SWEEP_PRESCALE_EN
            div_q    <= '0;
`endif
         end else begin
            case (state_q)
               ST_IDLE: begin
                  lim_q     <= bus.LIMIT;
                  mode_q    <= bus.MODE;
                  pos_q     <= bus.DIR ? bus.LIMIT : '0;
                  heading_q <= bus.DIR;
                  cnt_en_q  <= 1'b1;
                  state_q   <= ST_RUN;
`ifdef SWEEP_PRESCALE_EN
                  presc_q   <= bus.PRESC;
                  div_q     <= '0;
`endif
               end
               ST_RUN: begin
                  if (tick) begin
`ifdef SWEEP_PRESCALE_EN
                     div_q <= '0;
`endif
                     if (at_end) begin
                        done_q <= 1'b1;
                        if (mode_q) begin
                           heading_q <= ~heading_q;
                        end else begin
                           state_q  <= ST_DONE;
                           cnt_en_q <= 1'b0;
                        end
                     end else if (heading_q) begin
                        pos_q <= pos_q - 1'b1;
                     end else begin
                        pos_q <= pos_q + 1'b1;
                     end
                  end else begin
`ifdef SWEEP_PRESCALE_EN
                     div_q <= div_q + 1'b1;
`endif
                  end
               end
               ST_DONE: begin
                  cnt_en_q <= 1'b0;
               end
               default: begin
                  state_q  <= ST_IDLE;
                  pos_q    <= '0;
                  cnt_en_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.POS     = pos_q;
   assign bus.CNT_EN  = cnt_en_q;
   assign bus.DONE    = done_q;
   assign bus.HEADING = heading_q;

endmodule

// File: tb/tb_sweep_counter.sv
// tb_sweep_counter: directed self-checking bench for sweep_counter.
// Optional feature macro: SWEEP_PRESCALE_EN enables the divider scenario.
module tb_sweep_counter;

   logic CLK;
   logic RST_N;
   int   checks;
   int   passes;

   sweep_counter_if #(
      .WIDTH(13)
`ifdef SWEEP_PRESCALE_EN
      , .PRESCALE_W(8)
`endif
   ) bus ();

   sweep_counter #(
      .WIDTH(13)
`ifdef SWEEP_PRESCALE_EN
      , .PRESCALE_W(8)
`endif
   ) dut (
      .CLK  (CLK),
      .RST_N(RST_N),
      .bus  (bus)
   );

   // Free-running 10-unit clock.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_out();
      bus.EN = 1'b0;
      step();
   endtask

   task automatic test_reset();
      RST_N     = 1'b1;
      bus.EN    = 1'b0;
      bus.DIR   = 1'b0;
      bus.MODE  = 1'b0;
      bus.LIMIT = '0;
`ifdef SWEEP_PRESCALE_EN
      bus.PRESC = '0;
`endif
      #2 RST_N = 1'b0;
      #1;
      checks++; if (bus.POS !== 13'd0) $display("[TB] FAIL rst_pos: got %0d expected 0", bus.POS); else passes++;
      checks++; if (bus.CNT_EN !== 1'b0) $display("[TB] FAIL rst_cnt_en: got %b expected 0", bus.CNT_EN); else passes++;
      checks++; if (bus.DONE !== 1'b0) $display("[TB] FAIL rst_done: got %b expected 0", bus.DONE); else passes++;
      checks++; if (bus.HEADING !== 1'b0) $display("[TB] FAIL rst_heading: got %b expected 0", bus.HEADING); else passes++;
      @(negedge CLK);
      RST_N = 1'b1;
      step();
   endtask

   task automatic test_single_up();
      bus.LIMIT = 13'd15; bus.DIR = 1'b0; bus.MODE = 1'b0; bus.EN = 1'b1;
      step();
      checks++; if (bus.POS !== 13'd0 || bus.CNT_EN !== 1'b1) $display("[TB] FAIL up_entry: got pos %0d cnt_en %b expected pos 0 cnt_en 1", bus.POS, bus.CNT_EN); else passes++;
      for (int i = 1; i <= 15; i++) begin
         step();
         checks++;
         if (bus.POS !== 13'(i) || bus.CNT_EN !== 1'b1 || bus.DONE !== 1'b0)
            $display("[TB] FAIL up_step[%0d]: got pos %0d cnt_en %b done %b expected pos %0d cnt_en 1 done 0", i, bus.POS, bus.CNT_EN, bus.DONE, i);
         else passes++;
      end
      step();
      checks++; if (bus.DONE !== 1'b1 || bus.CNT_EN !== 1'b0 || bus.POS !== 13'd15) $display("[TB] FAIL up_end: got pos %0d cnt_en %b done %b expected pos 15 cnt_en 0 done 1", bus.POS, bus.CNT_EN, bus.DONE); else passes++;
      step();
      checks++; if (bus.DONE !== 1'b0 || bus.CNT_EN !== 1'b0 || bus.POS !== 13'd15) $display("[TB] FAIL up_hold: got pos %0d cnt_en %b done %b expected pos 15 cnt_en 0 done 0", bus.POS, bus.CNT_EN, bus.DONE); else passes++;
      idle_out();
      checks++; if (bus.POS !== 13'd0 || bus.CNT_EN !== 1'b0) $display("[TB] FAIL up_idle: got pos %0d cnt_en %b expected pos 0 cnt_en 0", bus.POS, bus.CNT_EN); else passes++;
   endtask

   task automatic test_single_down();
      bus.LIMIT = 13'd5; bus.DIR = 1'b1; bus.MODE = 1'b0; bus.EN = 1'b1;
      step();
      checks++; if (bus.POS !== 13'd5 || bus.HEADING !== 1'b1) $display("[TB] FAIL down_entry: got pos %0d heading %b expected pos 5 heading 1", bus.POS, bus.HEADING); else passes++;
      for (int i = 4; i >= 0; i--) begin
         step();
         checks++;
         if (bus.POS !== 13'(i) || bus.HEADING !== 1'b1 || bus.DONE !== 1'b0)
            $display("[TB] FAIL down_step[%0d]: got pos %0d heading %b done %b expected pos %0d heading 1 done 0", i, bus.POS, bus.HEADING, bus.DONE, i);
         else passes++;
      end
      step();
      checks++; if (bus.DONE !== 1'b1 || bus.CNT_EN !== 1'b0 || bus.POS !== 13'd0 || bus.HEADING !== 1'b1) $display("[TB] FAIL down_end: got pos %0d cnt_en %b done %b heading %b expected pos 0 cnt_en 0 done 1 heading 1", bus.POS, bus.CNT_EN, bus.DONE, bus.HEADING); else passes++;
      idle_out();
      checks++; if (bus.POS !== 13'd0 || bus.CNT_EN !== 1'b0 || bus.DONE !== 1'b0) $display("[TB] FAIL down_idle: got pos %0d cnt_en %b done %b expected 0 0 0", bus.POS, bus.CNT_EN, bus.DONE); else passes++;
   endtask

   task automatic test_bounce();
      int exp_pos[10]  = '{0, 1, 2, 3, 3, 2, 1, 0, 0, 1};
      bit exp_done[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0};
      bus.LIMIT = 13'd3; bus.DIR = 1'b0; bus.MODE = 1'b1; bus.EN = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if (bus.POS !== 13'(exp_pos[i]) || bus.DONE !== exp_done[i] || bus.CNT_EN !== 1'b1)
            $display("[TB] FAIL bounce[%0d]: got pos %0d done %b cnt_en %b expected pos %0d done %b cnt_en 1", i, bus.POS, bus.DONE, bus.CNT_EN, exp_pos[i], exp_done[i]);
         else passes++;
      end
      idle_out();
   endtask

   task automatic test_abort();
      bus.LIMIT = 13'd15; bus.DIR = 1'b0; bus.MODE = 1'b0; bus.EN = 1'b1;
      step();
      step();
      bus.LIMIT = 13'd2;
      for (int i = 2; i <= 7; i++) begin
         step();
         checks++;
         if (bus.POS !== 13'(i) || bus.DONE !== 1'b0)
            $display("[TB] FAIL abort_step[%0d]: got pos %0d done %b expected pos %0d done 0", i, bus.POS, bus.DONE, i);
         else passes++;
      end
      idle_out();
      checks++; if (bus.POS !== 13'd0 || bus.CNT_EN !== 1'b0 || bus.DONE !== 1'b0) $display("[TB] FAIL abort_idle: got pos %0d cnt_en %b done %b expected 0 0 0", bus.POS, bus.CNT_EN, bus.DONE); else passes++;
      // Drop EN on the very edge where end detection would otherwise fire.
      bus.LIMIT = 13'd1; bus.EN = 1'b1;
      step();
      step();
      checks++; if (bus.POS !== 13'd1) $display("[TB] FAIL abort_end_pos: got %0d expected 1", bus.POS); else passes++;
      idle_out();
      checks++; if (bus.DONE !== 1'b0 || bus.POS !== 13'd0 || bus.CNT_EN !== 1'b0) $display("[TB] FAIL abort_end_nodone: got pos %0d cnt_en %b done %b expected 0 0 0", bus.POS, bus.CNT_EN, bus.DONE); else passes++;
   endtask

   task automatic test_limit_zero();
      bus.LIMIT = 13'd0; bus.DIR = 1'b0; bus.MODE = 1'b1; bus.EN = 1'b1;
      step();
      checks++; if (bus.DONE !== 1'b0 || bus.POS !== 13'd0) $display("[TB] FAIL lz_entry: got pos %0d done %b expected pos 0 done 0", bus.POS, bus.DONE); else passes++;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (bus.DONE !== 1'b1 || bus.POS !== 13'd0 || bus.CNT_EN !== 1'b1)
            $display("[TB] FAIL lz_tick[%0d]: got pos %0d done %b cnt_en %b expected pos 0 done 1 cnt_en 1", i, bus.POS, bus.DONE, bus.CNT_EN);
         else passes++;
      end
      idle_out();
   endtask

   task automatic test_max_limit();
      bus.LIMIT = 13'h1FFF; bus.DIR = 1'b0; bus.MODE = 1'b1; bus.EN = 1'b1;
      step();
      for (int i = 0; i < 8191; i++) step();
      checks++; if (bus.POS !== 13'h1FFF || bus.DONE !== 1'b0) $display("[TB] FAIL max_top: got pos %0d done %b expected pos 8191 done 0", bus.POS, bus.DONE); else passes++;
      step();
      checks++; if (bus.POS !== 13'h1FFF || bus.DONE !== 1'b1) $display("[TB] FAIL max_end: got pos %0d done %b expected pos 8191 done 1", bus.POS, bus.DONE); else passes++;
      step();
      checks++; if (bus.POS !== 13'h1FFE || bus.HEADING !== 1'b1) $display("[TB] FAIL max_turn: got pos %0d heading %b expected pos 8190 heading 1", bus.POS, bus.HEADING); else passes++;
      idle_out();
   endtask

`ifdef SWEEP_PRESCALE_EN
   task automatic test_prescale();
      bus.LIMIT = 13'd2; bus.DIR = 1'b0; bus.MODE = 1'b0; bus.PRESC = 8'd3; bus.EN = 1'b1;
      step();
      bus.PRESC = 8'd0;
      for (int c = 1; c <= 12; c++) begin
         step();
         checks++;
         if (bus.POS !== 13'((c < 12) ? c / 4 : 2) || bus.DONE !== (c == 12))
            $display("[TB] FAIL presc[%0d]: got pos %0d done %b expected pos %0d done %b", c, bus.POS, bus.DONE, (c < 12) ? c / 4 : 2, c == 12);
         else passes++;
      end
      idle_out();
   endtask
`endif

   task automatic test_reset_mid_run();
      bus.LIMIT = 13'd15; bus.DIR = 1'b0; bus.MODE = 1'b0; bus.EN = 1'b1;
      for (int i = 0; i < 4; i++) step();
      #2 RST_N = 1'b0;
      #1;
      checks++; if (bus.POS !== 13'd0 || bus.CNT_EN !== 1'b0 || bus.DONE !== 1'b0) $display("[TB] FAIL mid_rst: got pos %0d cnt_en %b done %b expected 0 0 0", bus.POS, bus.CNT_EN, bus.DONE); else passes++;
      bus.EN = 1'b0;
      @(negedge CLK);
      RST_N = 1'b1;
      step();
      checks++; if (bus.POS !== 13'd0 || bus.CNT_EN !== 1'b0) $display("[TB] FAIL mid_rst_idle: got pos %0d cnt_en %b expected 0 0", bus.POS, bus.CNT_EN); else passes++;
   endtask

   // Run every scenario in order, then report.
   initial begin
      checks = 0;
      passes = 0;
      test_reset();
      test_single_up();
      test_single_down();
      test_bounce();
      test_abort();
      test_limit_zero();
      test_max_limit();
`ifdef SWEEP_PRESCALE_EN
      test_prescale();
`endif
      test_reset_mid_run();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/sweep_counter.md
# sweep_counter

Parametrised sweep counter for the servo calibration path. While the FSM holds `EN` high, it steps a position counter between 0 and a run-time `LIMIT`, either up or down. `CNT_EN` stays high while a sweep is in progress. `DONE` pulses for one cycle whenever an end point is reached. Single-shot mode stops at the end point; bounce mode reverses and sweeps continuously. This block supersedes the fixed-width horizontal/vertical sweep counters and serves both axes.

## Interface
- `WIDTH`, 13: width of `POS` and `LIMIT`.
- `PRESCALE_W`, 8: width of `PRESC`. Only used when `SWEEP_PRESCALE_EN` is defined.
- `CLK`  in  1: system clock, rising edge.
- `RST_N`  in  1: reset, asynchronous, active-low.
- `EN`  in  1: sweep enable from the FSM. Level-sensitive.
- `DIR`  in  1: start direction. 0 sweeps from 0 up to `LIMIT`; 1 sweeps from `LIMIT` down to 0.
- `MODE`  in  1: 0 is single-shot, 1 is bounce.
- `LIMIT`  in  WIDTH: sweep end point (unsigned).
- `PRESC`  in  PRESCALE_W: step period minus 1. Present only with `SWEEP_PRESCALE_EN`.
- `POS`  out  WIDTH: current position.
- `CNT_EN`  out  1: high while the state is RUN.
- `DONE`  out  1: one-cycle pulse when an end point is reached.
- `HEADING`  out  1: current step direction (0 = up, 1 = down). Valid in RUN and DONE.

## Operation
- States: IDLE, RUN, DONE. All state and outputs are registered.
- Reset (`RST_N` = 0, asynchronous): state goes to IDLE; `POS` = 0, `CNT_EN` = 0, `DONE` = 0, `HEADING` = 0; the prescaler clears.
- IDLE:
  - Outputs: `POS` = 0, `CNT_EN` = 0.
  - When `EN` = 1: latch `LIMIT`, `DIR`, `MODE` (and `PRESC`) into internal registers.
  - Load `POS` = `DIR` ? `LIMIT` : 0 and set `HEADING` = `DIR`.
  - Go to RUN and set `CNT_EN` = 1.
- RUN:
  - Each step tick moves `POS` by ±1 toward the end point. The end point is `LIMIT` when `HEADING` = 0 and 0 when `HEADING` = 1.
  - A tick with `POS` already equal to the end point does not step. Instead it pulses `DONE` = 1, and then:
    - Single-shot: go to DONE and set `CNT_EN` = 0.
    - Bounce: toggle `HEADING` and stay in RUN. `CNT_EN` stays 1.
- DONE: hold `POS` at the end point, `CNT_EN` = 0. Stay in DONE until `EN` = 0.
- `EN` = 0 in any state: go to IDLE on the next edge with `POS` = 0 and `CNT_EN` = 0. `DONE` is not asserted on that edge, even if a tick coincides with it.
- Latched `LIMIT`, `DIR`, `MODE` and `PRESC` are frozen for the whole run. Input changes take effect only after passing through IDLE.
- `LIMIT` = 0: `POS` = 0 is already the end point. The first tick pulses `DONE`. In bounce mode `DONE` then pulses on every tick and `POS` stays 0.
- `POS` never wraps and never goes outside 0..`LIMIT`. `LIMIT` = 2^WIDTH−1 is legal.

## Timing
- `EN` sampled high at edge k: at edge k the state is RUN, `POS` = start and `CNT_EN` = 1.
- Without prescaler, one tick per cycle:
  - `POS` steps at edges k+1 … k+L, where L = latched `LIMIT`.
  - End detection occurs at edge k+L+1. At that edge `DONE` = 1 for one cycle and, in single-shot mode, `CNT_EN` falls.
  - `CNT_EN` is therefore high for L+1 cycles.
- Bounce: the first step away from an end point happens at the tick after the `DONE` tick. A full round trip is 2L+2 ticks.
- Latency from `EN` low to `CNT_EN` low is one edge.

## Configuration
- Macro `SWEEP_PRESCALE_EN`.
- Defined:
  - The `PRESC` port and a PRESCALE_W-bit divider are present. A tick occurs every `PRESC`+1 cycles while in RUN.
  - The divider clears on entry to RUN and after each tick. The first tick comes `PRESC`+1 cycles after RUN entry.
  - `PRESC` = 0 behaves exactly like the undefined build.
- Undefined: no `PRESC` port and no divider; a tick occurs every cycle in RUN.

## Test plan
- Reset mid-run, `RST_N` pulsed low asynchronously → `POS` = 0, `CNT_EN` = 0, `DONE` = 0 immediately, before the next clock edge.
- Single-shot up, `LIMIT` = 15, `DIR` = 0, `MODE` = 0, `EN` held high:
  - `POS` goes 0..15 and `CNT_EN` is high for 16 cycles.
  - One `DONE` pulse occurs on the edge where `CNT_EN` falls; `POS` then holds 15.
- Single-shot down, `LIMIT` = 5, `DIR` = 1:
  - `POS` goes 5,4,3,2,1,0, then `DONE` pulses once.
  - `HEADING` = 1 throughout; `EN` low then returns the block to IDLE with `POS` = 0.
- Bounce, `LIMIT` = 3, `DIR` = 0:
  - `POS` sequence is 0,1,2,3,3,2,1,0,0,1 ….
  - `DONE` pulses on each repeated end value; `CNT_EN` stays 1.
- Abort, `EN` dropped at `POS` = 7 of `LIMIT` = 15 → next edge `POS` = 0, `CNT_EN` = 0, no `DONE`. A `LIMIT` change mid-run to 2 has no effect on the current sweep.
- `SWEEP_PRESCALE_EN` defined, `PRESC` = 3, `LIMIT` = 2:
  - `POS` steps every 4 cycles.
  - `DONE` occurs 12 cycles after RUN entry.
